// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS32 core: load image, release core, wait for HLT, read result.
// Latency: 1 program word per cycle while loading; HLT to done = 3 cycles (READ, CAPT, DONE).
// Backpressure: prog_ready only in LOAD; words are written combinationally on valid & ready.
module mips_run_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int LOAD_BASE   = 0,
  parameter int RESULT_ADDR = 198,
  parameter int TIMEOUT     = 2000,
  parameter int CNT_W       = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [31:0]       prog_data,
  input  logic              prog_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              core_run,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [31:0]       result,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_READ, S_CAPT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
  localparam logic [ADDR_W-1:0] RES_A    = ADDR_W'(RESULT_ADDR);
  localparam logic [CNT_W-1:0]  TO_LIM   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              xfer;
  logic              hit_timeout;
  logic [CNT_W-1:0]  run_cycles_inc;

  // Next-state and combinational outputs; reset forces everything quiet in the same cycle.
  always_comb begin
    state_nxt      = state;
    prog_ready     = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    core_run       = 1'b0;
    busy           = 1'b0;
    xfer           = 1'b0;
    run_cycles_inc = (run_cycles == CNT_MAX) ? run_cycles : run_cycles + CNT_W'(1);
    // The counter value this RUN cycle will leave behind is what the watchdog judges.
    hit_timeout    = (run_cycles_inc >= TO_LIM);
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        prog_ready = 1'b1;
        mem_addr   = wr_ptr;
        xfer       = prog_valid;
        if (prog_valid) begin
          mem_we    = 1'b1;
          mem_wdata = prog_data;
          if (prog_last)              state_nxt = S_RUN;
          else if (wr_ptr == PTR_MAX) state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        core_run = 1'b1;
        // Halt beats a watchdog expiry landing on the same cycle.
        if (core_halted)      state_nxt = S_READ;
        else if (hit_timeout) state_nxt = S_DONE;
      end
      S_READ: begin
        busy      = 1'b1;
        mem_addr  = RES_A;
        state_nxt = S_CAPT;
      end
      S_CAPT: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (rst) begin
      prog_ready = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      core_run   = 1'b0;
      busy       = 1'b0;
      xfer       = 1'b0;
    end
  end

  // State register plus write pointer, status flags, result and run counter.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= PTR_BASE;
      done       <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      result     <= '0;
      run_cycles <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            wr_ptr     <= PTR_BASE;
            done       <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            result     <= '0;
            run_cycles <= '0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (!prog_last && wr_ptr == PTR_MAX) begin
              overflow <= 1'b1;
              done     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          run_cycles <= run_cycles_inc;
          if (!core_halted && hit_timeout) begin
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        S_CAPT: begin
          result <= mem_rdata;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: behavioural memory and core stub, random images, gaps and halt times.
module tb_mips_run_ctrl;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int RES_A = 198;
  localparam int TMO   = 20;
  localparam int CW    = 16;

  localparam logic [31:0] FACT_IMG [11] = '{
    32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000, 32'h14431000,
    32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe, 32'hfc000000};

  logic          clk1 = 1'b0;
  logic          rst, start, prog_valid, prog_ready, prog_last, mem_we;
  logic          core_run, core_halted, busy, done, timeout, overflow;
  logic [31:0]   prog_data, mem_wdata, mem_rdata, result;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] run_cycles;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] img [300];
  int          wlog_a[$];
  logic [31:0] wlog_d[$];
  int          bad_we = 0;
  int          run_cnt = 0;
  int          halt_at = 1000;
  bit          stale_halt = 1'b0;
  int          arg_val = 0;

  always #5 clk1 = ~clk1;

  mips_run_ctrl #(.ADDR_W(AW), .LOAD_BASE(0), .RESULT_ADDR(RES_A), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk1(clk1), .rst(rst), .start(start), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_data(prog_data), .prog_last(prog_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_run(core_run), .core_halted(core_halted),
    .busy(busy), .done(done), .timeout(timeout), .overflow(overflow), .result(result),
    .run_cycles(run_cycles));

  function automatic logic [31:0] fact(input int n);
    logic [31:0] f;
    f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * 32'(i);
    return f;
  endfunction

  // Core stub: halts in its halt_at-th running cycle, having stored fact(arg_val) at RES_A.
  assign core_halted = stale_halt | (core_run && (run_cnt + 1 >= halt_at));

  // Synchronous memory, write log and illegal-write monitor.
  always @(posedge clk1) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wlog_a.push_back(int'(mem_addr));
      wlog_d.push_back(mem_wdata);
      if (!(prog_valid && prog_ready) || core_run) bad_we <= bad_we + 1;
    end
    if (core_run && core_halted && !stale_halt) mem[RES_A] <= fact(arg_val);
    mem_rdata <= mem[mem_addr];
    run_cnt   <= core_run ? run_cnt + 1 : 0;
  end

  // Mismatches between the write log since wb and the image at addresses 0..n-1 (-1 on count error).
  function automatic int log_errs(input int wb, input int n);
    int e = 0;
    if (wlog_a.size() != wb + n) return -1;
    for (int i = 0; i < n; i++)
      if (wlog_a[wb+i] != i || wlog_d[wb+i] !== img[i]) e++;
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clk1); start = 1'b1;
    @(negedge clk1); start = 1'b0;
  endtask

  task automatic drive_image(input int n, input bit use_last, input int gap);
    int idx = 0;
    int cyc = 0;
    bit v;
    while (idx < n && cyc < 4000) begin
      @(negedge clk1);
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      prog_valid = v;
      prog_data  = img[idx];
      prog_last  = use_last && (idx == n - 1);
      #1;
      if (done) break;
      if (v && prog_ready) idx++;
      cyc++;
    end
  endtask

  task automatic wait_done(output int run_obs, output int lat, output bit got_done);
    int halt_c = -1;
    run_obs = 0; lat = -1; got_done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk1);
      prog_valid = 1'b0; prog_last = 1'b0; stale_halt = 1'b0;
      #1;
      if (core_run) run_obs++;
      if (core_run && core_halted) halt_c = c;
      if (done) begin
        got_done = 1'b1;
        if (halt_c >= 0) lat = c - halt_c;
        break;
      end
    end
  endtask

  task automatic run_image(input int n, input bit use_last, input int gap,
                           output int wb, output int ro, output int lat, output bit gd);
    wb = wlog_a.size();
    pulse_start();
    drive_image(n, use_last, gap);
    wait_done(ro, lat, gd);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; prog_valid = 1'b1; prog_last = 1'b0; prog_data = 32'hdeadbeef;
    repeat (2) @(negedge clk1);
    #1;
    checks++;
    if ({prog_ready, mem_we, core_run, busy, done, timeout, overflow} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000000", {prog_ready, mem_we, core_run, busy, done, timeout, overflow});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_mem got addr=%0d wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (result !== '0 || run_cycles !== '0) begin
      failures++; $display("FAIL reset_result got result=%0d run_cycles=%0d want 0/0", result, run_cycles);
    end
    rst = 1'b0; start = 1'b0; prog_valid = 1'b0;
    @(negedge clk1); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_factorial();
    int wb, ro, lat, e;
    bit gd;
    for (int i = 0; i < 11; i++) img[i] = FACT_IMG[i];
    arg_val = 7; halt_at = 12; stale_halt = 1'b1;
    run_image(11, 1'b1, 0, wb, ro, lat, gd);
    e = log_errs(wb, 11);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL fact_writes got errs=%0d want 0", e); end
    checks++;
    if (gd !== 1'b1 || timeout !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL fact_flags got done=%b timeout=%b overflow=%b want 1/0/0", gd, timeout, overflow);
    end
    checks++;
    if (result !== 32'd5040) begin failures++; $display("FAIL fact_result got=%0d want=5040", result); end
    checks++;
    if (run_cycles !== CW'(12) || ro !== 12) begin
      failures++; $display("FAIL fact_cycles got run_cycles=%0d run_obs=%0d want 12/12", run_cycles, ro);
    end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL fact_latency got=%0d want=3", lat); end
    checks++;
    if (busy !== 1'b0 || core_run !== 1'b0) begin
      failures++; $display("FAIL fact_idle got busy=%b core_run=%b want 0/0", busy, core_run);
    end
  endtask

  task automatic test_gaps();
    int wb, ro, lat, e, h, a;
    bit gd;
    for (int i = 0; i < 15; i++) img[i] = $urandom();
    h = $urandom_range(1, TMO); a = $urandom_range(0, 10);
    arg_val = a; halt_at = h;
    run_image(15, 1'b1, 1, wb, ro, lat, gd);
    e = log_errs(wb, 15);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL gaps_writes got errs=%0d want 0", e); end
    checks++;
    if (gd !== 1'b1 || timeout !== 1'b0 || result !== fact(a) || run_cycles !== CW'(h)) begin
      failures++;
      $display("FAIL gaps_run got done=%b timeout=%b result=%0d cycles=%0d want 1/0/%0d/%0d",
               gd, timeout, result, run_cycles, fact(a), h);
    end
  endtask

  task automatic test_random();
    int wb, ro, lat, e, n, h, a, exp_rc;
    bit gd, exp_to;
    logic [31:0] exp_res;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 60); h = $urandom_range(1, TMO + 6); a = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) img[i] = $urandom();
      arg_val = a; halt_at = h; stale_halt = ($urandom_range(0, 1) == 1);
      exp_to  = (h > TMO);
      exp_rc  = exp_to ? TMO : h;
      exp_res = exp_to ? 32'd0 : fact(a);
      run_image(n, 1'b1, 2, wb, ro, lat, gd);
      e = log_errs(wb, n);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL rand%0d_writes got errs=%0d want 0", it, e); end
      checks++;
      if (gd !== 1'b1 || timeout !== exp_to || result !== exp_res || run_cycles !== CW'(exp_rc) || ro !== exp_rc) begin
        failures++;
        $display("FAIL rand%0d_run got done=%b to=%b res=%0d cyc=%0d obs=%0d want 1/%b/%0d/%0d/%0d",
                 it, gd, timeout, result, run_cycles, ro, exp_to, exp_res, exp_rc, exp_rc);
      end
    end
  endtask

  task automatic test_watchdog();
    int wb, ro, lat;
    bit gd;
    for (int i = 0; i < 5; i++) img[i] = $urandom();
    arg_val = 3; halt_at = 1000;
    run_image(5, 1'b1, 0, wb, ro, lat, gd);
    checks++;
    if (gd !== 1'b1 || timeout !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL wdog_flags got done=%b timeout=%b overflow=%b want 1/1/0", gd, timeout, overflow);
    end
    checks++;
    if (run_cycles !== CW'(TMO) || ro !== TMO || core_run !== 1'b0) begin
      failures++;
      $display("FAIL wdog_cycles got cyc=%0d obs=%0d core_run=%b want %0d/%0d/0", run_cycles, ro, core_run, TMO, TMO);
    end
    checks++;
    if (result !== 32'd0) begin failures++; $display("FAIL wdog_result got=%0d want=0", result); end
  endtask

  task automatic test_halt_on_timeout();
    int wb, ro, lat;
    bit gd;
    for (int i = 0; i < 7; i++) img[i] = $urandom();
    arg_val = 9; halt_at = TMO;
    run_image(7, 1'b1, 0, wb, ro, lat, gd);
    checks++;
    if (gd !== 1'b1 || timeout !== 1'b0 || result !== fact(9) || run_cycles !== CW'(TMO) || lat !== 3) begin
      failures++;
      $display("FAIL halt_tmo got done=%b timeout=%b result=%0d cyc=%0d lat=%0d want 1/0/%0d/%0d/3",
               gd, timeout, result, run_cycles, lat, fact(9), TMO);
    end
  endtask

  task automatic test_overflow();
    int wb, ro, lat, e;
    bit gd;
    for (int i = 0; i < DEPTH + 1; i++) img[i] = $urandom();
    halt_at = 1; arg_val = 1;
    run_image(DEPTH + 1, 1'b0, 2, wb, ro, lat, gd);
    e = log_errs(wb, DEPTH);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL ovf_writes got errs=%0d want 0", e); end
    checks++;
    if (gd !== 1'b1 || overflow !== 1'b1 || timeout !== 1'b0) begin
      failures++; $display("FAIL ovf_flags got done=%b overflow=%b timeout=%b want 1/1/0", gd, overflow, timeout);
    end
    checks++;
    if (ro !== 0 || prog_ready !== 1'b0) begin
      failures++; $display("FAIL ovf_core got run_obs=%0d prog_ready=%b want 0/0", ro, prog_ready);
    end
  endtask

  task automatic test_midrun_reset();
    int wb, ro, lat, e;
    bit gd;
    for (int i = 0; i < 11; i++) img[i] = FACT_IMG[i];
    arg_val = 7; halt_at = 15;
    pulse_start();
    drive_image(11, 1'b1, 0);
    @(negedge clk1); prog_valid = 1'b0; prog_last = 1'b0;   // RUN cycle 1
    @(negedge clk1); start = 1'b1;                          // RUN cycle 2
    @(negedge clk1); start = 1'b0; #1;                      // RUN cycle 3
    checks++;
    if (core_run !== 1'b1 || busy !== 1'b1 || run_cycles !== CW'(2)) begin
      failures++;
      $display("FAIL start_in_run got core_run=%b busy=%b cyc=%0d want 1/1/2", core_run, busy, run_cycles);
    end
    @(negedge clk1);                                        // RUN cycle 4
    @(negedge clk1); rst = 1'b1;                            // RUN cycle 5
    @(negedge clk1); #1;
    checks++;
    if ({prog_ready, mem_we, core_run, busy, done, timeout, overflow} !== 7'b0 ||
        result !== '0 || run_cycles !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL midrun_reset got flags=%b result=%0d cyc=%0d addr=%0d want all 0",
               {prog_ready, mem_we, core_run, busy, done, timeout, overflow}, result, run_cycles, mem_addr);
    end
    rst = 1'b0;
    halt_at = 12;
    run_image(11, 1'b1, 1, wb, ro, lat, gd);
    e = log_errs(wb, 11);
    checks++;
    if (e !== 0 || gd !== 1'b1 || result !== 32'd5040 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL restart got errs=%0d done=%b result=%0d timeout=%b want 0/1/5040/0", e, gd, result, timeout);
    end
  endtask

  task automatic test_no_stray_writes();
    checks++;
    if (bad_we !== 0) begin failures++; $display("FAIL stray_we got=%0d want=0", bad_we); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
    test_reset();
    test_factorial();
    test_gaps();
    test_random();
    test_watchdog();
    test_halt_on_timeout();
    test_overflow();
    test_midrun_reset();
    test_no_stray_writes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
